// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch-stage initiator for the instruction cache read port. Issues one-word
// reads, buffers the returned words with their PCs in a small in-order FIFO,
// and presents them to decode through a valid/ready handshake. A redirect
// flushes the in-flight read and the whole buffer and restarts fetching.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   imem_enable        read request to the instruction cache
//   imem_address       byte address of the request (always fetch_pc)
//   imem_data          word returned one cycle after the request
//   redirect_valid     flush and restart at redirect_pc (bits [1:0] ignored)
//   redirect_pc        new fetch address
//   out_valid          out_instruction / out_pc hold a valid entry
//   out_ready          decode accepts the current entry
//   out_instruction    fetched instruction word (head of buffer)
//   out_pc             byte address of out_instruction
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  imem_enable,
    output logic [ADDR_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    // State
    logic [ADDR_WIDTH-1:0]        fetch_pc_q,   fetch_pc_d;
    logic                         pending_q,    pending_d;
    logic [ADDR_WIDTH-1:0]        pending_pc_q, pending_pc_d;
    entry_t [FIFO_DEPTH-1:0]      fifo_q,       fifo_d;
    logic [PTR_W-1:0]             head_q,       head_d;
    logic [PTR_W-1:0]             tail_q,       tail_d;
    logic [CNT_W-1:0]             count_q,      count_d;

    // Per-cycle events
    logic                         issue;
    logic                         push;
    logic                         pop;
    logic [CNT_W-1:0]             occupancy;

    // Slots already spoken for: buffered entries plus the word still coming
    // back from the cache. Issuing only while this is below the depth
    // guarantees every returned word has a slot, and keeps out_ready off the
    // memory-port path.
    always_comb begin
        occupancy = count_q + {{(CNT_W-1){1'b0}}, pending_q};
        // reset_n gating forces the request low for the whole reset window,
        // including a reset asserted between clock edges.
        issue     = reset_n && !redirect_valid && (occupancy < DEPTH_C);
        push      = pending_q && !redirect_valid;
        pop       = out_valid && out_ready;
    end

    assign imem_enable     = issue;
    assign imem_address    = fetch_pc_q;
    assign out_valid       = (count_q != '0) && !redirect_valid;
    assign out_instruction = fifo_q[head_q].instr;
    assign out_pc          = fifo_q[head_q].pc;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_d    = issue;
        pending_pc_d = pending_pc_q;
        fifo_d       = fifo_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;

        if (redirect_valid) begin
            // Drop everything, including the word returning this cycle.
            fetch_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            pending_d  = 1'b0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d   = fetch_pc_q + ADDR_WIDTH'(4);
                pending_pc_d = fetch_pc_q;
            end
            if (push) begin
                fifo_d[tail_q] = '{instr: imem_data, pc: pending_pc_q};
                tail_d         = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q   <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            fifo_q       <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            fifo_q       <= fifo_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch (ADDR_WIDTH=8 so address wrap is
// reachable). A queue-level model (fetch address, one in-flight PC, queue of
// buffered PCs) predicts every output on every falling edge; directed phases
// add literal expectations on latency and delivered PC sequences.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset_n;
    logic          imem_enable;
    logic [AW-1:0] imem_address;
    logic [DW-1:0] imem_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instruction;
    logic [AW-1:0] out_pc;

    instruction_fetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RESET_PC   (8'h00),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .imem_enable     (imem_enable),
        .imem_address    (imem_address),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc)
    );

    int errors = 0;
    int checks = 0;

    // Memory contents are a fixed function of the address.
    function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction cache: one-cycle registered read, holds while idle.
    always @(posedge clk) begin
        if (imem_enable) imem_data <= word(imem_address);
    end

    // ---------------- behavioural model ----------------
    logic [AW-1:0] m_fetch   = 8'h00;
    int            m_pend    = 0;
    logic [AW-1:0] m_pend_pc = 8'h00;
    logic [AW-1:0] mq[$];

    initial begin
        bit en;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                m_pend  = 0;
                m_fetch = 8'h00;
            end else if (redirect_valid) begin
                mq.delete();
                m_pend  = 0;
                m_fetch = redirect_pc & 8'hFC;
            end else begin
                en = (mq.size() + m_pend) < DEPTH;
                if (mq.size() != 0 && out_ready) void'(mq.pop_front());
                if (m_pend != 0) mq.push_back(m_pend_pc);
                m_pend = en ? 1 : 0;
                if (en) begin
                    m_pend_pc = m_fetch;
                    m_fetch   = m_fetch + 8'd4;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [AW-1:0] got[$];
    int            en_cycles = 0;

    initial begin
        bit en_exp, v_exp;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_imem_enable", {31'b0, imem_enable}, 0);
                chk("rst_out_valid", {31'b0, out_valid}, 0);
                chk("rst_imem_address", {24'b0, imem_address}, 0);
                chk("rst_out_pc", {24'b0, out_pc}, 0);
                chk("rst_out_instruction", out_instruction, 0);
            end else begin
                en_exp = !redirect_valid && ((mq.size() + m_pend) < DEPTH);
                v_exp  = (mq.size() != 0) && !redirect_valid;
                chk("imem_enable", {31'b0, imem_enable}, {31'b0, en_exp});
                chk("imem_address", {24'b0, imem_address}, {24'b0, m_fetch});
                chk("out_valid", {31'b0, out_valid}, {31'b0, v_exp});
                if (v_exp) begin
                    chk("out_pc", {24'b0, out_pc}, {24'b0, mq[0]});
                    chk("out_instruction", out_instruction, word(mq[0]));
                end
                if (imem_enable) en_cycles++;
                if (out_valid && out_ready) got.push_back(out_pc);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Delivered PCs must be exactly n entries: start, start+4, ... (mod 256).
    task automatic check_seq(input string name, input logic [AW-1:0] start, input int n);
        logic [AW-1:0] want;
        chk({name, "_len"}, got.size(), n);
        want = start;
        for (int i = 0; i < n; i++) begin
            chk(name, (i < got.size()) ? {24'b0, got[i]} : 32'hFFFF_FFFF, {24'b0, want});
            want = want + 8'd4;
        end
    endtask

    task automatic do_reset(input logic ready);
        reset_n   = 1'b0;
        out_ready = ready;
        step(2);
        reset_n   = 1'b1;
        en_cycles = 0;
        got.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed phases ----------------
    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b1;
        step(2);

        // Reset start: literal latency and first words.
        chk("lit_rst_enable", {31'b0, imem_enable}, 0);
        chk("lit_rst_valid", {31'b0, out_valid}, 0);
        reset_n = 1'b1;
        got.delete();
        #1;
        chk("lit_t0_enable", {31'b0, imem_enable}, 1);
        chk("lit_t0_address", {24'b0, imem_address}, 32'h00);
        step(1);
        chk("lit_t1_valid", {31'b0, out_valid}, 0);
        step(1);
        chk("lit_t2_valid", {31'b0, out_valid}, 1);
        chk("lit_t2_pc", {24'b0, out_pc}, 32'h00);
        chk("lit_t2_instr", out_instruction, 32'hC300FF5A);
        step(8);
        check_seq("start_seq", 8'h00, 8);

        // Back-pressure: ready low from reset through 10 cycles after first valid.
        do_reset(1'b0);
        step(12);
        chk("bp_issued", en_cycles, 4);
        chk("bp_enable_low", {31'b0, imem_enable}, 0);
        chk("bp_head_pc", {24'b0, out_pc}, 32'h00);
        chk("bp_none_taken", got.size(), 0);
        out_ready = 1'b1;
        step(8);
        check_seq("bp_seq", 8'h00, 8);

        // Redirect while one read is in flight and two entries are buffered,
        // with ready high in that same cycle (push and pop both suppressed).
        do_reset(1'b0);
        step(3);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        out_ready      = 1'b1;
        got.delete();
        #1;
        chk("rd_valid_low", {31'b0, out_valid}, 0);
        chk("rd_enable_low", {31'b0, imem_enable}, 0);
        step(1);
        redirect_valid = 1'b0;
        #1;
        chk("rd_r1_enable", {31'b0, imem_enable}, 1);
        chk("rd_r1_address", {24'b0, imem_address}, 32'h40);
        step(1);
        chk("rd_r2_valid", {31'b0, out_valid}, 0);
        step(1);
        chk("rd_r3_valid", {31'b0, out_valid}, 1);
        chk("rd_r3_pc", {24'b0, out_pc}, 32'h40);
        step(4);
        check_seq("rd_seq", 8'h40, 4);

        // Redirect held for three cycles: only the last PC is fetched.
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        step(1);
        redirect_pc    = 8'h90;
        step(1);
        redirect_pc    = 8'hA0;
        step(1);
        redirect_valid = 1'b0;
        got.delete();
        #1;
        chk("held_address", {24'b0, imem_address}, 32'hA0);
        step(6);
        check_seq("held_seq", 8'hA0, 4);

        // Misaligned redirect near the top of the address space: wrap to 0.
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        step(1);
        redirect_valid = 1'b0;
        got.delete();
        #1;
        chk("wrap_address", {24'b0, imem_address}, 32'hFC);
        step(6);
        check_seq("wrap_seq", 8'hFC, 4);

        // Reset asserted between clock edges while streaming.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_enable", {31'b0, imem_enable}, 0);
        chk("mid_rst_valid", {31'b0, out_valid}, 0);
        step(1);
        reset_n = 1'b1;
        got.delete();
        #1;
        chk("mid_restart_address", {24'b0, imem_address}, 32'h00);
        chk("mid_restart_enable", {31'b0, imem_enable}, 1);
        step(4);
        check_seq("mid_seq", 8'h00, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch-stage initiator for the instruction memory read port. It issues one-word read requests to the instruction cache, which has one-cycle registered read latency and holds its data while enable is low. Returned words are buffered in a small in-order FIFO and handed to decode through a valid/ready handshake together with their PC. Branch and jump redirects flush all in-flight and buffered fetches.

## Interface
- DATA_WIDTH, 32: instruction width in bits; fixed at 32.
- ADDR_WIDTH, 32: byte-address width.
- RESET_PC, 0: first fetch address after reset; must be 4-byte aligned.
- FIFO_DEPTH, 4: instruction buffer entries; power of two, at least 2.
- clk  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- imem_enable  output  1  read request; maps to the read modport enable.
- imem_address  output  ADDR_WIDTH  byte address of the request; maps to the read modport address.
- imem_data  input  DATA_WIDTH  word returned one cycle after the request; maps to the read modport data.
- redirect_valid  input  1  flush the pipeline and restart fetching at redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] are ignored and treated as 0.
- out_valid  output  1  out_instruction and out_pc are valid.
- out_ready  input  1  decode accepts the current entry.
- out_instruction  output  DATA_WIDTH  fetched instruction word.
- out_pc  output  ADDR_WIDTH  byte address of out_instruction.

## Operation
- **State:**
  - fetch_pc: next address to request.
  - pending and pending_pc: a request was issued in the previous cycle.
  - FIFO: instruction/PC pairs, head pointer, tail pointer, count (0..FIFO_DEPTH).
- **Issue rule:** imem_enable = !redirect_valid && (count + pending < FIFO_DEPTH).
  - The rule does not depend on out_ready, so there is no combinational path from out_ready to the memory port.
  - imem_address = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4 (modulo 2^ADDR_WIDTH, wraps to 0); pending <= 1; pending_pc <= fetch_pc.
  - Without issue: pending <= 0.
- **Push:** when pending = 1 and no redirect, the pair {imem_data, pending_pc} is written at tail in that cycle.
  - A FIFO slot is always available, because of the issue credit rule.
- **Pop:** out_valid = (count != 0) && !redirect_valid; out_instruction/out_pc come from the head entry.
  - A pop occurs when out_valid && out_ready.
  - A simultaneous push and pop leaves count unchanged.
- **Redirect (highest priority):**
  - In the cycle redirect_valid = 1: no issue, no push, no pop.
  - At the clock edge: count <= 0, pointers <= 0, pending <= 0 (the in-flight response is discarded), fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - A redirect held for several cycles repeats this each cycle; the last redirect_pc wins.
- **Ordering:** instructions leave in strictly ascending PC order between redirects, with no drops or duplicates.

## Timing
- **Reset (async, immediate):**
  - Outputs: imem_enable 0, out_valid 0, imem_address RESET_PC, out_instruction 0, out_pc 0.
  - State: fetch_pc RESET_PC, pending 0, count 0.
- **After reset release:** first request at RESET_PC in the first cycle; out_valid in the third cycle (T0 request, T1 data and push, T2 visible).
- **Request latency:** a request issued at cycle T appears on out_valid no earlier than T+2.
- **Redirect latency:** redirect in cycle R gives a request to redirect_pc at R+1 and out_valid with out_pc = redirect_pc at R+3.
- **Steady-state throughput:** one instruction per cycle with out_ready held high (FIFO_DEPTH ≥ 4).
- **Back-pressure:** with out_ready low, issue stops once count + pending = FIFO_DEPTH; the FIFO holds exactly FIFO_DEPTH entries and nothing is lost.
- **Held outputs:** out_instruction and out_pc stay stable while out_valid && !out_ready.
- **Reset mid-operation:** all in-flight and buffered entries are discarded; the sequence restarts at RESET_PC.

## Test plan
- **Reset start:** memory holds words W0..W7 at addresses 0..28, RESET_PC=0, out_ready=1 → out_valid rises 2 cycles after the first request; then out_pc 0,4,8,… with matching words, one per cycle.
- **Back-pressure:** out_ready=0 for 10 cycles after the first valid → exactly 4 requests outstanding/buffered, imem_enable low thereafter; after release, PCs 0..12 appear in order with no gap or duplicate.
- **Redirect with in-flight request:** redirect_valid for one cycle with redirect_pc=0x40 while pending=1 and count=2 → out_valid low in the redirect cycle; next out_pc 0x40 at R+3; no stale PC is ever delivered.
- **Misaligned redirect and wrap:** ADDR_WIDTH=8, redirect_pc=0xFE → fetch starts at 0xFC, then wraps to 0x00, 0x04.
- **Simultaneous events:** a redirect in the same cycle as a push and a pop with out_ready=1 → the FIFO ends empty and no handshake is counted in that cycle; a redirect held for 3 cycles with changing PCs → only the final PC is fetched.
- **Mid-run reset:** reset_n asserted asynchronously between clock edges → imem_enable and out_valid drop immediately; after release, fetch restarts at RESET_PC.
